// File: rtl/trap_controller.sv
// rtl/trap_controller.sv - trap sequencer driving MEPC capture and PC redirect
module trap_controller #(
    parameter logic [31:0] TRAP_VECTOR   = 32'h0000_0100,
    parameter int          PENDING_WIDTH = 4
) (
    input  logic                     clock,
    input  logic                     resetActiveLow,
    input  logic                     interruptRequest,
    input  logic                     interruptEnable,
    input  logic                     mretDetected,
    input  logic [31:0]              mepcValue,
    output logic                     csrWriteEnable,
    output logic                     coreHalt,
    output logic                     pcOverride,
    output logic [31:0]              pcOverrideValue,
    output logic                     inHandler,
    output logic [PENDING_WIDTH-1:0] pendingCount
);

    typedef enum logic [2:0] {
        IDLE,
        SAVE,
        VECTOR,
        HANDLER,
        RETURN
    } state_t;

    localparam logic [PENDING_WIDTH-1:0] PENDING_MAX  = '1;
    localparam logic [PENDING_WIDTH-1:0] PENDING_ZERO = '0;
    localparam logic [PENDING_WIDTH-1:0] PENDING_ONE  = {{(PENDING_WIDTH-1){1'b0}}, 1'b1};

    state_t state;

    // Trap sequence; traps are only taken from IDLE, so nothing nests inside HANDLER
    always_ff @(posedge clock or negedge resetActiveLow) begin
        if (!resetActiveLow) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (pendingCount != PENDING_ZERO && interruptEnable) state <= SAVE;
                SAVE:    state <= VECTOR;
                VECTOR:  state <= HANDLER;
                HANDLER: if (mretDetected) state <= RETURN;
                RETURN:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Saturating pending counter; a request landing on the SAVE cycle cancels the decrement
    always_ff @(posedge clock or negedge resetActiveLow) begin
        if (!resetActiveLow) begin
            pendingCount <= PENDING_ZERO;
        end else if (interruptRequest && state == SAVE) begin
            pendingCount <= pendingCount;
        end else if (interruptRequest && pendingCount != PENDING_MAX) begin
            pendingCount <= pendingCount + PENDING_ONE;
        end else if (state == SAVE && pendingCount != PENDING_ZERO) begin
            pendingCount <= pendingCount - PENDING_ONE;
        end
    end

    // Moore decode from the registered state; RETURN forwards the live MEPC so handler writes stick
    always_comb begin
        csrWriteEnable  = 1'b0;
        coreHalt        = 1'b0;
        pcOverride      = 1'b0;
        pcOverrideValue = 32'h0;
        inHandler       = 1'b0;
        case (state)
            SAVE: begin
                csrWriteEnable = 1'b1;
                coreHalt       = 1'b1;
                inHandler      = 1'b1;
            end
            VECTOR: begin
                pcOverride      = 1'b1;
                pcOverrideValue = TRAP_VECTOR;
                coreHalt        = 1'b1;
                inHandler       = 1'b1;
            end
            HANDLER: begin
                inHandler = 1'b1;
            end
            RETURN: begin
                pcOverride      = 1'b1;
                pcOverrideValue = mepcValue;
                inHandler       = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_trap_controller.sv
// tb/tb_trap_controller.sv - directed vector bench for trap_controller
module tb_trap_controller;

    logic        clock;
    logic        resetActiveLow;
    logic        interruptRequest;
    logic        interruptEnable;
    logic        mretDetected;
    logic [31:0] mepcValue;
    logic        csrWriteEnable;
    logic        coreHalt;
    logic        pcOverride;
    logic [31:0] pcOverrideValue;
    logic        inHandler;
    logic [3:0]  pendingCount;

    int checks;
    int errors;

    trap_controller #(
        .TRAP_VECTOR   (32'h0000_0100),
        .PENDING_WIDTH (4)
    ) dut (
        .clock            (clock),
        .resetActiveLow   (resetActiveLow),
        .interruptRequest (interruptRequest),
        .interruptEnable  (interruptEnable),
        .mretDetected     (mretDetected),
        .mepcValue        (mepcValue),
        .csrWriteEnable   (csrWriteEnable),
        .coreHalt         (coreHalt),
        .pcOverride       (pcOverride),
        .pcOverrideValue  (pcOverrideValue),
        .inHandler        (inHandler),
        .pendingCount     (pendingCount)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        irq;
        logic        en;
        logic        mret;
        logic [31:0] mepc;
        logic        we;
        logic        halt;
        logic        ovr;
        logic [31:0] val;
        logic        inh;
        logic [3:0]  pend;
    } vec_t;

    vec_t tbl [31];

    task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got we/halt/ovr/val/inh/pend=%h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [39:0] outs();
        return {csrWriteEnable, coreHalt, pcOverride, pcOverrideValue, inHandler, pendingCount};
    endfunction

    function automatic logic [39:0] pack(input logic we, input logic halt, input logic ovr,
                                         input logic [31:0] val, input logic inh, input logic [3:0] pend);
        return {we, halt, ovr, val, inh, pend};
    endfunction

    task automatic step(input logic irq, input logic en, input logic mret, input logic [31:0] mepc);
        @(negedge clock);
        interruptRequest = irq;
        interruptEnable  = en;
        mretDetected     = mret;
        mepcValue        = mepc;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clock);
        resetActiveLow   = 1'b0;
        interruptRequest = 1'b0;
        interruptEnable  = 1'b0;
        mretDetected     = 1'b0;
        mepcValue        = 32'h0;
        @(negedge clock);
        resetActiveLow = 1'b1;
    endtask

    initial begin
        logic saw_we;
        checks = 0;
        errors = 0;
        resetActiveLow   = 1'b0;
        interruptRequest = 1'b0;
        interruptEnable  = 1'b0;
        mretDetected     = 1'b0;
        mepcValue        = 32'h0;

        //           irq  en   mret mepc          we   halt ovr  val           inh  pend
        tbl[0]  = '{1'b1,1'b1,1'b0,32'h40,       1'b0,1'b0,1'b0,32'h0,       1'b0,4'd1};
        tbl[1]  = '{1'b0,1'b1,1'b0,32'h40,       1'b1,1'b1,1'b0,32'h0,       1'b1,4'd1};
        tbl[2]  = '{1'b0,1'b1,1'b0,32'h40,       1'b0,1'b1,1'b1,32'h100,     1'b1,4'd0};
        tbl[3]  = '{1'b0,1'b1,1'b0,32'h40,       1'b0,1'b0,1'b0,32'h0,       1'b1,4'd0};
        tbl[4]  = '{1'b0,1'b1,1'b0,32'h44,       1'b0,1'b0,1'b0,32'h0,       1'b1,4'd0};
        tbl[5]  = '{1'b0,1'b1,1'b1,32'h44,       1'b0,1'b0,1'b1,32'h44,      1'b1,4'd0};
        tbl[6]  = '{1'b0,1'b1,1'b0,32'h44,       1'b0,1'b0,1'b0,32'h0,       1'b0,4'd0};
        tbl[7]  = '{1'b0,1'b1,1'b1,32'h44,       1'b0,1'b0,1'b0,32'h0,       1'b0,4'd0};
        tbl[8]  = '{1'b1,1'b1,1'b0,32'h44,       1'b0,1'b0,1'b0,32'h0,       1'b0,4'd1};
        tbl[9]  = '{1'b0,1'b1,1'b0,32'h44,       1'b1,1'b1,1'b0,32'h0,       1'b1,4'd1};
        tbl[10] = '{1'b1,1'b1,1'b0,32'h44,       1'b0,1'b1,1'b1,32'h100,     1'b1,4'd1};
        tbl[11] = '{1'b1,1'b1,1'b0,32'h44,       1'b0,1'b0,1'b0,32'h0,       1'b1,4'd2};
        tbl[12] = '{1'b1,1'b1,1'b0,32'h44,       1'b0,1'b0,1'b0,32'h0,       1'b1,4'd3};
        tbl[13] = '{1'b0,1'b1,1'b1,32'h48,       1'b0,1'b0,1'b1,32'h48,      1'b1,4'd3};
        tbl[14] = '{1'b0,1'b1,1'b0,32'h48,       1'b0,1'b0,1'b0,32'h0,       1'b0,4'd3};
        tbl[15] = '{1'b0,1'b1,1'b0,32'h48,       1'b1,1'b1,1'b0,32'h0,       1'b1,4'd3};
        tbl[16] = '{1'b0,1'b0,1'b0,32'h48,       1'b0,1'b1,1'b1,32'h100,     1'b1,4'd2};
        tbl[17] = '{1'b0,1'b0,1'b0,32'h48,       1'b0,1'b0,1'b0,32'h0,       1'b1,4'd2};
        tbl[18] = '{1'b0,1'b0,1'b1,32'h48,       1'b0,1'b0,1'b1,32'h48,      1'b1,4'd2};
        tbl[19] = '{1'b0,1'b0,1'b0,32'h48,       1'b0,1'b0,1'b0,32'h0,       1'b0,4'd2};
        tbl[20] = '{1'b0,1'b0,1'b0,32'h48,       1'b0,1'b0,1'b0,32'h0,       1'b0,4'd2};
        tbl[21] = '{1'b0,1'b1,1'b0,32'h48,       1'b1,1'b1,1'b0,32'h0,       1'b1,4'd2};
        tbl[22] = '{1'b0,1'b1,1'b0,32'h48,       1'b0,1'b1,1'b1,32'h100,     1'b1,4'd1};
        tbl[23] = '{1'b0,1'b1,1'b1,32'h48,       1'b0,1'b0,1'b0,32'h0,       1'b1,4'd1};
        tbl[24] = '{1'b0,1'b1,1'b1,32'h4c,       1'b0,1'b0,1'b1,32'h4c,      1'b1,4'd1};
        tbl[25] = '{1'b0,1'b1,1'b0,32'h4c,       1'b0,1'b0,1'b0,32'h0,       1'b0,4'd1};
        tbl[26] = '{1'b0,1'b1,1'b0,32'h4c,       1'b1,1'b1,1'b0,32'h0,       1'b1,4'd1};
        tbl[27] = '{1'b0,1'b1,1'b0,32'h4c,       1'b0,1'b1,1'b1,32'h100,     1'b1,4'd0};
        tbl[28] = '{1'b0,1'b1,1'b0,32'h4c,       1'b0,1'b0,1'b0,32'h0,       1'b1,4'd0};
        tbl[29] = '{1'b0,1'b1,1'b1,32'h50,       1'b0,1'b0,1'b1,32'h50,      1'b1,4'd0};
        tbl[30] = '{1'b0,1'b1,1'b0,32'h50,       1'b0,1'b0,1'b0,32'h0,       1'b0,4'd0};

        // Reset state held over idle cycles
        #1;
        check("reset_async", outs(), pack(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 4'd0));
        do_reset();
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b0, 32'h0);
        check("idle_20", outs(), pack(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 4'd0));

        // Trap entry, MEPC rewrite, queued traps, enable gating
        for (int i = 0; i < 31; i++) begin
            step(tbl[i].irq, tbl[i].en, tbl[i].mret, tbl[i].mepc);
            check($sformatf("vec%0d", i), outs(),
                  pack(tbl[i].we, tbl[i].halt, tbl[i].ovr, tbl[i].val, tbl[i].inh, tbl[i].pend));
        end

        // Saturation with enable low, then a single trap on enable
        do_reset();
        saw_we = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b0, 1'b0, 32'h0);
            saw_we = saw_we | csrWriteEnable;
        end
        step(1'b0, 1'b0, 1'b0, 32'h0);
        saw_we = saw_we | csrWriteEnable;
        check("saturate", outs(), pack(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 4'd15));
        check("no_we_disabled", {39'h0, saw_we}, 40'h0);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        check("sat_save", outs(), pack(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 4'd15));
        step(1'b0, 1'b1, 1'b0, 32'h0);
        check("sat_vector", outs(), pack(1'b0, 1'b1, 1'b1, 32'h100, 1'b1, 4'd14));

        // Asynchronous reset in VECTOR
        do_reset();
        step(1'b1, 1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        check("pre_reset_vector", outs(), pack(1'b0, 1'b1, 1'b1, 32'h100, 1'b1, 4'd1));
        #1;
        resetActiveLow = 1'b0;
        #1;
        check("async_reset_drop", outs(), pack(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 4'd0));
        @(negedge clock);
        resetActiveLow = 1'b1;
        step(1'b0, 1'b1, 1'b0, 32'h0);
        check("idle_after_reset", outs(), pack(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 4'd0));

        // MRET in IDLE is ignored
        step(1'b0, 1'b1, 1'b1, 32'h1234);
        check("mret_idle", outs(), pack(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 4'd0));
        step(1'b0, 1'b1, 1'b0, 32'h1234);
        check("mret_idle_after", outs(), pack(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 4'd0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
